// File: rtl/alu_mac_seq_if.sv
// Handshake/operand bundle for alu_mac_seq: core drives through master, the ALU sits on slave.
// The ovf flag only exists when ALU_OVF_FLAG_EN is defined.
interface alu_mac_seq_if #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ALU_SEL_W = 5
) ();

   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_W-1:0]    inp_a;
   logic [DATA_W-1:0]    inp_b;
   logic [ALU_SEL_W-1:0] alu_sel;
   logic                 acc_clr;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATA_W-1:0]    out;
   logic                 busy;
`ifdef ALU_OVF_FLAG_EN
   logic                 ovf;
`endif

   modport master (
      output in_valid, inp_a, inp_b, alu_sel, acc_clr, out_ready,
`ifdef ALU_OVF_FLAG_EN
      input  ovf,
`endif
      input  in_ready, out_valid, out, busy
   );

   modport slave (
      input  in_valid, inp_a, inp_b, alu_sel, acc_clr, out_ready,
`ifdef ALU_OVF_FLAG_EN
      output ovf,
`endif
      output in_ready, out_valid, out, busy
   );

endinterface

// File: rtl/alu_mac_seq.sv
// Registered RV32-style ALU with iterative shift-add multiplier, accumulator and valid/ready.
// Optional signed-overflow flag enabled by defining ALU_OVF_FLAG_EN.
module alu_mac_seq #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ALU_SEL_W = 5,
   parameter int unsigned MUL_BITS  = 1
) (
   input logic          clk,
   input logic          rst,
   alu_mac_seq_if.slave bus
);

   localparam int unsigned ShW    = $clog2(DATA_W);
   localparam int unsigned NSteps = DATA_W / MUL_BITS;
   localparam int unsigned CntW   = $clog2(NSteps + 1);

   localparam logic [ALU_SEL_W-1:0] OpAdd   = ALU_SEL_W'(0);
   localparam logic [ALU_SEL_W-1:0] OpAnd   = ALU_SEL_W'(1);
   localparam logic [ALU_SEL_W-1:0] OpOr    = ALU_SEL_W'(2);
   localparam logic [ALU_SEL_W-1:0] OpXor   = ALU_SEL_W'(3);
   localparam logic [ALU_SEL_W-1:0] OpSrl   = ALU_SEL_W'(4);
   localparam logic [ALU_SEL_W-1:0] OpSra   = ALU_SEL_W'(5);
   localparam logic [ALU_SEL_W-1:0] OpSll   = ALU_SEL_W'(6);
   localparam logic [ALU_SEL_W-1:0] OpSlt   = ALU_SEL_W'(7);
   localparam logic [ALU_SEL_W-1:0] OpSub   = ALU_SEL_W'(8);
   localparam logic [ALU_SEL_W-1:0] OpBsel  = ALU_SEL_W'(9);
   localparam logic [ALU_SEL_W-1:0] OpMul   = ALU_SEL_W'(10);
   localparam logic [ALU_SEL_W-1:0] OpMac   = ALU_SEL_W'(11);
   localparam logic [ALU_SEL_W-1:0] OpRdacc = ALU_SEL_W'(12);

   if ((DATA_W % MUL_BITS) != 0 || DATA_W < 8 || (DATA_W & (DATA_W - 1)) != 0) begin : g_param_err
      $error("alu_mac_seq: illegal DATA_W/MUL_BITS combination");
   end

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] prod_q, prod_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              is_mac_q, is_mac_d;

   logic              in_ready;
   logic              accept;
   logic              is_mul_op;
   logic [ShW-1:0]    shamt;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] step_add;
   logic [DATA_W-1:0] prod_next;
   logic [DATA_W-1:0] mac_sum;
   logic              last_step;

   assign in_ready  = !rst && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
   assign accept    = bus.in_valid && in_ready;
   assign is_mul_op = (bus.alu_sel == OpMul) || (bus.alu_sel == OpMac);
   assign shamt     = bus.inp_b[ShW-1:0];
   assign sum       = bus.inp_a + bus.inp_b;
   assign diff      = bus.inp_a - bus.inp_b;
   assign last_step = (state_q == StMul) && (count_q == CntW'(1));

   // Single-cycle result path; rdacc returns the accumulator before any clear.
   always_comb begin
      alu_res = '0;
      case (bus.alu_sel)
         OpAdd:   alu_res = sum;
         OpAnd:   alu_res = bus.inp_a & bus.inp_b;
         OpOr:    alu_res = bus.inp_a | bus.inp_b;
         OpXor:   alu_res = bus.inp_a ^ bus.inp_b;
         OpSrl:   alu_res = bus.inp_a >> shamt;
         OpSra:   alu_res = $unsigned($signed(bus.inp_a) >>> shamt);
         OpSll:   alu_res = bus.inp_a << shamt;
         OpSlt:   alu_res = {{(DATA_W-1){1'b0}}, $signed(bus.inp_a) < $signed(bus.inp_b)};
         OpSub:   alu_res = diff;
         OpBsel:  alu_res = bus.inp_b;
         OpRdacc: alu_res = acc_q;
         default: alu_res = '0;
      endcase
   end

   // One shift-add step retires MUL_BITS multiplier bits; low bits match for signed operands.
   always_comb begin
      step_add = '0;
      for (int i = 0; i < int'(MUL_BITS); i++) begin
         if (mplier_q[i]) step_add = step_add + (mcand_q << i);
      end
   end

   assign prod_next = prod_q + step_add;
   assign mac_sum   = acc_q + prod_next;

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      prod_d      = prod_q;
      count_d     = count_q;
      is_mac_d    = is_mac_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (bus.acc_clr) acc_d = '0;
               if (is_mul_op) begin
                  state_d  = StMul;
                  mcand_d  = bus.inp_a;
                  mplier_d = bus.inp_b;
                  prod_d   = '0;
                  count_d  = CntW'(NSteps);
                  is_mac_d = (bus.alu_sel == OpMac);
               end else begin
                  out_d       = alu_res;
                  out_valid_d = 1'b1;
               end
            end
         end
         StMul: begin
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            prod_d   = prod_next;
            count_d  = count_q - CntW'(1);
            if (last_step) begin
               state_d     = StIdle;
               out_valid_d = 1'b1;
               if (is_mac_q) begin
                  acc_d = mac_sum;
                  out_d = mac_sum;
               end else begin
                  out_d = prod_next;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         prod_q      <= '0;
         count_q     <= '0;
         is_mac_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         prod_q      <= prod_d;
         count_q     <= count_d;
         is_mac_q    <= is_mac_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.busy      = (state_q == StMul);

`ifdef ALU_OVF_FLAG_EN
   localparam int unsigned Msb = DATA_W - 1;

   logic ovf_q, ovf_d;
   logic alu_ovf;
   logic mac_ovf;

   always_comb begin
      alu_ovf = 1'b0;
      if (bus.alu_sel == OpAdd) begin
         alu_ovf = (bus.inp_a[Msb] == bus.inp_b[Msb]) && (sum[Msb] != bus.inp_a[Msb]);
      end else if (bus.alu_sel == OpSub) begin
         alu_ovf = (bus.inp_a[Msb] != bus.inp_b[Msb]) && (diff[Msb] != bus.inp_a[Msb]);
      end
   end

   assign mac_ovf = (acc_q[Msb] == prod_next[Msb]) && (mac_sum[Msb] != acc_q[Msb]);

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == StIdle && accept && !is_mul_op) begin
         ovf_d = alu_ovf;
      end else if (last_step) begin
         ovf_d = is_mac_q && mac_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_mac_seq.sv
// Directed, table-driven bench for alu_mac_seq (DATA_W=32, MUL_BITS=1).
module tb_alu_mac_seq;

   localparam int NS = 32;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_AND   = 5'd1;
   localparam logic [4:0] OP_OR    = 5'd2;
   localparam logic [4:0] OP_XOR   = 5'd3;
   localparam logic [4:0] OP_SRL   = 5'd4;
   localparam logic [4:0] OP_SRA   = 5'd5;
   localparam logic [4:0] OP_SLL   = 5'd6;
   localparam logic [4:0] OP_SLT   = 5'd7;
   localparam logic [4:0] OP_SUB   = 5'd8;
   localparam logic [4:0] OP_BSEL  = 5'd9;
   localparam logic [4:0] OP_MUL   = 5'd10;
   localparam logic [4:0] OP_MAC   = 5'd11;
   localparam logic [4:0] OP_RDACC = 5'd12;
   localparam logic [4:0] OP_BAD   = 5'd31;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   alu_mac_seq_if #(.DATA_W(32), .ALU_SEL_W(5)) bus ();

   alu_mac_seq #(.DATA_W(32), .ALU_SEL_W(5), .MUL_BITS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic        clr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic clr);
      bus.in_valid = 1'b1;
      bus.alu_sel  = sel;
      bus.inp_a    = a;
      bus.inp_b    = b;
      bus.acc_clr  = clr;
   endtask

   // Single-cycle op: accept on the next edge, result visible right after it.
   task automatic do_op(input string nm, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic clr, input logic [31:0] exp);
      drive(sel, a, b, clr);
      #1;
      chk({nm, "_ready"}, 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      bus.acc_clr  = 1'b0;
      chk(nm, {31'd0, bus.out_valid, bus.out}, {31'd0, 1'b1, exp});
   endtask

   // mul/mac: garbage in_valid during iteration must be ignored.
   task automatic run_mul(input string nm, input logic [4:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic clr, input logic [31:0] exp);
      int busy_cnt;
      busy_cnt = 0;
      drive(sel, a, b, clr);
      #1;
      chk({nm, "_ready"}, 64'(bus.in_ready), 64'd1);
      step();
      drive(OP_ADD, 32'd1, 32'd1, 1'b1);
      for (int k = 0; k < NS; k++) begin
         if (bus.busy && !bus.in_ready && !bus.out_valid) busy_cnt++;
         step();
      end
      bus.in_valid = 1'b0;
      bus.acc_clr  = 1'b0;
      chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(NS));
      chk(nm, {30'd0, bus.busy, bus.out_valid, bus.out}, {30'd0, 1'b0, 1'b1, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int quiet_bad;
      total = 0;
      bad   = 0;
      vecs[0]  = '{OP_ADD,   32'd7,          32'hFFFF_FFFD, 1'b0, 32'd4};
      vecs[1]  = '{OP_AND,   32'hF0F0_1234,  32'h0FF0_FF00, 1'b0, 32'h00F0_1200};
      vecs[2]  = '{OP_OR,    32'hF000_0001,  32'h0000_0F00, 1'b0, 32'hF000_0F01};
      vecs[3]  = '{OP_XOR,   32'hAAAA_5555,  32'hFFFF_0000, 1'b0, 32'h5555_5555};
      vecs[4]  = '{OP_SRA,   32'h8000_0000,  32'd4,         1'b0, 32'hF800_0000};
      vecs[5]  = '{OP_SRL,   32'h8000_0000,  32'd4,         1'b0, 32'h0800_0000};
      vecs[6]  = '{OP_SLL,   32'd1,          32'd31,        1'b0, 32'h8000_0000};
      vecs[7]  = '{OP_SLL,   32'd1,          32'd33,        1'b0, 32'd2};
      vecs[8]  = '{OP_SLT,   32'hFFFF_FFFF,  32'd1,         1'b0, 32'd1};
      vecs[9]  = '{OP_SLT,   32'd1,          32'hFFFF_FFFF, 1'b0, 32'd0};
      vecs[10] = '{OP_SUB,   32'd5,          32'd7,         1'b0, 32'hFFFF_FFFE};
      vecs[11] = '{OP_SUB,   32'h8000_0000,  32'd1,         1'b0, 32'h7FFF_FFFF};
      vecs[12] = '{OP_ADD,   32'hFFFF_FFFF,  32'd1,         1'b1, 32'd0};
      vecs[13] = '{OP_BSEL,  32'h1111_1111,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
      vecs[14] = '{OP_BAD,   32'h1234_5678,  32'h9ABC_DEF0, 1'b0, 32'd0};
      vecs[15] = '{OP_RDACC, 32'h1234_5678,  32'h9ABC_DEF0, 1'b0, 32'd0};

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.inp_a     = '0;
      bus.inp_b     = '0;
      bus.alu_sel   = '0;
      bus.acc_clr   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) step();
      bus.in_valid = 1'b1;
      #1;
      chk("reset_state", {60'd0, bus.in_ready, bus.out_valid, bus.busy, |bus.out}, 64'd0);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;

      // Back-to-back single-cycle ops; each result drains as the next is accepted.
      for (int i = 0; i < 16; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].clr,
               vecs[i].exp);
      end
      step();
      chk("drain_idle", 64'(bus.out_valid), 64'd0);

      run_mul("mul_neg", OP_MUL, 32'hFFFF_FFFA, 32'd7, 1'b0, 32'hFFFF_FFD6);
      step();

      run_mul("mac1", OP_MAC, 32'd3, 32'd4, 1'b1, 32'd12);
      run_mul("mac2", OP_MAC, 32'd5, 32'd5, 1'b0, 32'd37);
      do_op("rdacc1", OP_RDACC, 32'd0, 32'd0, 1'b0, 32'd37);
      do_op("rdacc_clr", OP_RDACC, 32'd0, 32'd0, 1'b1, 32'd37);
      do_op("rdacc_zero", OP_RDACC, 32'd0, 32'd0, 1'b0, 32'd0);
      run_mul("mac_clr_neg", OP_MAC, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 32'd6);

      // Output stall blocks acceptance; sub enters on the edge the add drains.
      do_op("stall_add", OP_ADD, 32'd2, 32'd3, 1'b0, 32'd5);
      bus.out_ready = 1'b0;
      drive(OP_SUB, 32'd10, 32'd4, 1'b0);
      #1;
      chk("stall_ready_low", 64'(bus.in_ready), 64'd0);
      step();
      step();
      chk("stall_hold", {29'd0, bus.in_ready, 1'b0, bus.out_valid, bus.out},
          {29'd0, 1'b0, 1'b0, 1'b1, 32'd5});
      bus.out_ready = 1'b1;
      #1;
      chk("stall_release_ready", 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      chk("stall_sub", {31'd0, bus.out_valid, bus.out}, {31'd0, 1'b1, 32'd6});
      step();
      chk("stall_drained", 64'(bus.out_valid), 64'd0);

      // Reset mid-multiply after loading a nonzero accumulator.
      run_mul("mac_pre_rst", OP_MAC, 32'd2, 32'd3, 1'b1, 32'd6);
      drive(OP_MUL, 32'd1000, 32'd3, 1'b0);
      step();
      bus.in_valid = 1'b0;
      repeat (10) step();
      chk("mid_mul_busy", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rst_abort", {61'd0, bus.busy, bus.out_valid, bus.in_ready}, 64'd1);
      quiet_bad = 0;
      for (int k = 0; k < NS + 4; k++) begin
         if (bus.out_valid || bus.busy) quiet_bad++;
         step();
      end
      chk("rst_no_result", 64'(quiet_bad), 64'd0);
      do_op("rst_acc_zero", OP_RDACC, 32'd0, 32'd0, 1'b0, 32'd0);

`ifdef ALU_OVF_FLAG_EN
      do_op("ovf_add", OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000);
      chk("ovf_add_flag", 64'(bus.ovf), 64'd1);
      do_op("ovf_add_ok", OP_ADD, 32'd1, 32'd1, 1'b0, 32'd2);
      chk("ovf_add_ok_flag", 64'(bus.ovf), 64'd0);
      do_op("ovf_sub", OP_SUB, 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF);
      chk("ovf_sub_flag", 64'(bus.ovf), 64'd1);
      do_op("ovf_xor", OP_XOR, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFE);
      chk("ovf_xor_flag", 64'(bus.ovf), 64'd0);
`endif

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_mac_seq.md
Name: alu_mac_seq

Overview:
- Parametrised, registered successor to the combinational RV32 ALU.
- Keeps the base opcode set (add, and, or, xor, srl, sra, sll, slt, sub, bsel).
- Adds an iterative shift-add multiplier, a multiply-accumulate with an internal accumulator, and valid/ready handshakes on input and output.
- Sits in the execute stage between operand muxes and writeback; the core stalls on in_ready/out_valid.

Parameters:
- DATA_W, 32, operand/result width; must be a power of two, at least 8.
- ALU_SEL_W, 5, opcode width.
- MUL_BITS, 1, multiplier bits retired per cycle; must divide DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept an operation.
- inp_a  in  DATA_W  signed operand A.
- inp_b  in  DATA_W  signed operand B.
- alu_sel  in  ALU_SEL_W  opcode.
- acc_clr  in  1  clear accumulator; qualified with the input handshake.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  DATA_W  registered result.
- busy  out  1  high while the multiplier is iterating.

Behaviour:
- Reset and clocking:
  - One clock domain. Reset is synchronous and active-high.
  - Reset values: out=0, out_valid=0, busy=0, acc=0, state=IDLE.
  - in_ready is combinational; it is 0 during rst.
- Acceptance:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on a rising edge where in_valid && in_ready.
- Output handshake:
  - out and out_valid hold until the edge where out_valid && out_ready.
  - On that edge out_valid clears, unless a new single-cycle result loads on the same edge; then out_valid stays 1 with the new value.
- Opcodes:
  - 00000 add; 00001 and; 00010 or; 00011 xor.
  - 00100 srl; 00101 sra; 00110 sll. Shift amount is inp_b[log2(DATA_W)-1:0].
  - 00111 slt: signed compare, result 1 or 0.
  - 01000 sub; 01001 bsel (out = inp_b).
  - 01010 mul: low DATA_W bits of the signed product.
  - 01011 mac: acc <= acc + low(a*b); out = new acc.
  - 01100 rdacc: out = acc.
  - Any other opcode: out = 0 with normal latency, no side effects.
- Arithmetic: add, sub and mac wrap modulo 2^DATA_W. The low product bits are identical for signed and unsigned operands.
- Latency:
  - Single-cycle ops (all except mul/mac): result registered on the accepting edge; out_valid is high the next cycle.
  - mul/mac: the accepting edge latches a, b and the opcode, clears the partial product, and sets count = DATA_W/MUL_BITS.
  - N = DATA_W/MUL_BITS; default 32 cycles.
  - mul/mac edges 1..N each retire MUL_BITS multiplier bits.
  - On edge N: out is written, out_valid=1, acc is updated for mac, and state returns to IDLE.
- FSM:
  - IDLE -> MUL on acceptance of mul/mac.
  - MUL -> MUL while count>1.
  - MUL -> IDLE on the final step.
  - busy = (state==MUL).
- Accumulator rules:
  - acc_clr is sampled only on an accepting edge.
  - With rdacc: out = old acc, then acc clears.
  - With mac: the clear applies first, so acc = low(a*b).
  - With any other opcode: acc clears; the result is unaffected.
- Boundaries:
  - in_valid during MUL is ignored; in_ready=0.
  - A stalled output (out_ready=0) blocks acceptance but not an in-flight multiply's internal progress.
  - A multiply finishing while the previous result is still unconsumed cannot occur, because acceptance required the output slot to be free or draining.
  - rst mid-MUL aborts the operation; all state returns to reset values on that edge and no result is produced.

Optional Feature:
- Macro ALU_OVF_FLAG_EN.
- When defined:
  - Adds output port ovf (1 bit, reset 0), registered alongside out.
  - ovf=1 when add, sub or mac overflows signed DATA_W; otherwise 0.
  - ovf is 0 for all other ops.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then add a=7, b=-3 with out_ready=1 -> out_valid the next cycle with out=4; in_ready=1 throughout.
- sra a=0x80000000, b=4 -> out=0xF8000000. srl with the same operands -> 0x08000000. slt a=-1, b=1 -> 1.
- mul a=-6, b=7, MUL_BITS=1 -> busy for 32 cycles, in_ready=0, out=0xFFFFFFD6 exactly 32 cycles after acceptance.
- mac 3x4 with acc_clr=1, then mac 5x5, then rdacc -> outputs 12, 37, 37. Then rdacc with acc_clr=1 -> 37, and a following rdacc -> 0.
- Hold out_ready=0 after an add result; offer a sub -> in_ready=0 and out holds. Raise out_ready -> sub accepted on the same edge the add drains, and the sub result follows the next cycle.
- Assert rst 10 cycles into a mul -> next cycle busy=0, out_valid=0, acc=0, in_ready=1, and no result emitted. With ALU_OVF_FLAG_EN, add 0x7FFFFFFF+1 -> ovf=1.
